rate_mult_rx: RTL and testbench
===============================

RATE_MULT_RX -- requirements
Module: rate_mult_rx

Interface
REQ-001 The module SHALL have parameter CNT_W, default 16, giving the frame counter width; the recovered word is CNT_W+1 bits.
REQ-002 The module SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port pp_0, input, 1 bit: enable strobe; a cycle with pp_0=1 is an enabled cycle.
REQ-005 The module SHALL have port pz, input, 1 bit: serial rate-multiplier stream, sampled only on enabled cycles.
REQ-006 The module SHALL have port pready, input, 1 bit: consumer ready.
REQ-007 The module SHALL have port pc, output, CNT_W+1 bits: recovered word.
REQ-008 The module SHALL have port pvalid, output, 1 bit: pc holds an unconsumed word.
REQ-009 The module SHALL have port perr, output, 1 bit: consistency error flag for the word in pc.
REQ-010 The module SHALL have port povr, output, 1 bit: sticky overrun flag.
REQ-011 The module SHALL have port povr_clr, input, 1 bit: clears povr.

Function
REQ-012 On each enabled cycle, a CNT_W-bit counter c SHALL increment by 1, wrapping from all-ones to 0; c SHALL hold on cycles with pp_0=0.
REQ-013 On each enabled cycle, the bit index k SHALL equal the number of trailing ones of c (range 0..CNT_W).
REQ-014 When c == 2^k-1 (first occurrence of k in the frame), shadow bit k SHALL capture pz.
REQ-015 On every other enabled cycle, if pz != shadow[k], a frame error bit SHALL be set; it clears at frame start.
REQ-016 The enabled cycle with c all-ones SHALL complete the frame.
- The completing cycle's pz SHALL form bit CNT_W of the word.
- pc, perr and pvalid SHALL update on the next edge, giving a latency of 1 cycle.
REQ-017 A word SHALL be consumed on a cycle with pvalid=1 and pready=1; pvalid SHALL drop on the next edge unless a frame completes on the same cycle.
REQ-018 If a frame completes while pvalid=1 and pready=1, the new word SHALL load and pvalid SHALL stay 1.
REQ-019 If a frame completes while pvalid=1 and pready=0, the new word SHALL be dropped, pc/perr SHALL be unchanged, and an overrun event SHALL occur.
REQ-020 pc and perr SHALL be stable while pvalid=1 and the word is not consumed.
REQ-021 The shadow word and frame error SHALL reset to 0 at the start of each frame (c=0).

Reset
REQ-022 While reset=1, on each edge: c, shadow, frame error, pc, pvalid, perr and povr SHALL be 0.
REQ-023 Reset SHALL take priority over pp_0, pready and povr_clr; a partial frame SHALL be discarded.
REQ-024 The first enabled cycle after reset SHALL be c=0.

Configuration
REQ-025 With macro RATE_MULT_RX_OVR_EN defined, povr SHALL set on an overrun event and hold until povr_clr=1 or reset.
- Set SHALL win over a simultaneous povr_clr.
REQ-026 Without RATE_MULT_RX_OVR_EN, povr SHALL be constant 0, povr_clr SHALL be ignored, and dropping behaviour SHALL be unchanged.

Verification (CNT_W=4, 16-cycle frames)
REQ-027 Reset, then 16 enabled cycles with pz from the encoder for word 5'b10110 and pready=1 -> pc=5'b10110, perr=0, pvalid=1 for exactly 1 cycle, 1 cycle after c=15.
REQ-028 Same stream with pp_0 low on every other cycle -> identical pc; pvalid asserts 1 cycle after the 16th enabled cycle.
REQ-029 Stream for word 5'b00001 with pz flipped at c=2 (k=0 repeat) -> pc=5'b00001, perr=1; the next clean frame gives perr=0.
REQ-030 pready=0 across two complete frames (words 5'h0A then 5'h15) -> pc stays 5'h0A, povr=1 with macro and 0 without; povr_clr=1 -> povr=0.
REQ-031 pready=1 asserted exactly on a frame-completion cycle with a pending word -> the new word loads, pvalid stays 1, povr stays 0.
REQ-032 reset=1 at c=9 mid-frame with pvalid=1 -> all outputs 0 next cycle; the following full frame decodes correctly from c=0.

Source files
------------

// File: rtl/rate_mult_rx.sv
// Rate-multiplier stream decoder: recovers a CNT_W+1 bit word per 2^CNT_W enabled cycles.
// Latency: word appears 1 cycle after the all-ones frame cycle; holds until pready; drops new word if still pending.
// Optional RATE_MULT_RX_OVR_EN: sticky povr flag on dropped words, cleared by povr_clr.
module rate_mult_rx #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pp_0,
    input  logic             pz,
    input  logic             pready,
    input  logic             povr_clr,
    output logic [CNT_W:0]   pc,
    output logic             pvalid,
    output logic             perr,
    output logic             povr
);
    localparam int KW = $clog2(CNT_W + 1);

    logic [CNT_W-1:0] c_q, c_d, c_inc;
    logic [CNT_W:0]   shadow_q, shadow_d;
    logic             ferr_q, ferr_d;
    logic [CNT_W:0]   pc_q, pc_d;
    logic             perr_q, perr_d;
    logic             pvalid_q, pvalid_d;
    logic [KW-1:0]    k;
    logic             run;
    logic             first_occ;
    logic             complete;
    logic             ovr_ev;

    assign c_inc = c_q + 1'b1;
    // c == 2^k-1 exactly when c and c+1 share no set bits (all-ones wraps to 0)
    assign first_occ = ((c_q & c_inc) == '0);
    assign complete  = pp_0 && (&c_q);

    always_comb begin
        k   = '0;
        run = 1'b1;
        for (int i = 0; i < CNT_W; i++) begin
            if (run && c_q[i]) begin
                k = k + 1'b1;
            end else begin
                run = 1'b0;
            end
        end
    end

    always_comb begin
        c_d      = c_q;
        shadow_d = shadow_q;
        ferr_d   = ferr_q;
        pc_d     = pc_q;
        perr_d   = perr_q;
        pvalid_d = pvalid_q;
        ovr_ev   = 1'b0;

        if (pp_0) begin
            c_d = c_inc;
            if (c_q == '0) begin
                shadow_d = '0;
                ferr_d   = 1'b0;
            end
            if (first_occ) begin
                shadow_d[k] = pz;
            end else if (pz != shadow_q[k]) begin
                ferr_d = 1'b1;
            end
        end

        // The completing cycle is always a first occurrence, so shadow_d holds the full word
        if (complete) begin
            if (!pvalid_q || pready) begin
                pc_d     = shadow_d;
                perr_d   = ferr_q;
                pvalid_d = 1'b1;
            end else begin
                ovr_ev = 1'b1;
            end
        end else if (pvalid_q && pready) begin
            pvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            c_q      <= '0;
            shadow_q <= '0;
            ferr_q   <= 1'b0;
            pc_q     <= '0;
            perr_q   <= 1'b0;
            pvalid_q <= 1'b0;
        end else begin
            c_q      <= c_d;
            shadow_q <= shadow_d;
            ferr_q   <= ferr_d;
            pc_q     <= pc_d;
            perr_q   <= perr_d;
            pvalid_q <= pvalid_d;
        end
    end

    assign pc     = pc_q;
    assign perr   = perr_q;
    assign pvalid = pvalid_q;

`ifdef RATE_MULT_RX_OVR_EN
    logic povr_q;

    // A new overrun beats a simultaneous clear
    always_ff @(posedge clock) begin
        if (reset) begin
            povr_q <= 1'b0;
        end else if (ovr_ev) begin
            povr_q <= 1'b1;
        end else if (povr_clr) begin
            povr_q <= 1'b0;
        end
    end

    assign povr = povr_q;
`else
    logic unused_ovr;

    assign unused_ovr = povr_clr ^ ovr_ev;
    assign povr       = 1'b0;
`endif

endmodule

// File: tb/tb_rate_mult_rx.sv
// Scoreboard bench for rate_mult_rx at CNT_W=4: encoder-driven frames, queue of expected words, decoupled monitor.
module tb_rate_mult_rx;
    localparam int W = 4;
`ifdef RATE_MULT_RX_OVR_EN
    localparam bit OVR_EXP = 1'b1;
`else
    localparam bit OVR_EXP = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset, pp_0, pz, pready, povr_clr;
    logic [W:0]   pc;
    logic         pvalid, perr, povr;

    rate_mult_rx #(.CNT_W(W)) dut (
        .clock   (clock),
        .reset   (reset),
        .pp_0    (pp_0),
        .pz      (pz),
        .pready  (pready),
        .povr_clr(povr_clr),
        .pc      (pc),
        .pvalid  (pvalid),
        .perr    (perr),
        .povr    (povr)
    );

    always #5 clock = ~clock;

    int           checks = 0;
    int           errors = 0;
    int           drops  = 0;
    logic [W+1:0] exp_q[$];
    logic [W+1:0] e;
    bit           exp_vld = 1'b0;
    bit           exp_ovr = 1'b0;
    bit           mon_en  = 1'b0;

    function automatic int tz(input int c);
        int n = 0;
        while (n < W && ((c >> n) & 1) == 1) n++;
        return n;
    endfunction

    function automatic bit first_occ(input int c);
        return c == ((1 << tz(c)) - 1);
    endfunction

    function automatic logic enc(input logic [W:0] w, input int c);
        return w[tz(c)];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a word is consumed at the edge following a negedge with pvalid && pready
    always @(negedge clock) begin
        if (mon_en) begin
            check("pvalid", int'(pvalid), int'(exp_vld));
            check("povr", int'(povr), int'(exp_ovr));
            if (pvalid && pready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_empty actual=pvalid_with_word expected=no_word at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("pc", int'(pc), int'(e[W:0]));
                    check("perr", int'(perr), int'(e[W+1]));
                end
            end
        end
    end

    task automatic step(input bit rst, input bit en, input bit z, input bit rdy, input bit clr,
                        input bit cmpl, input logic [W:0] w, input bit err);
        bit ev;
        reset    = rst;
        pp_0     = en;
        pz       = z;
        pready   = rdy;
        povr_clr = clr;
        @(posedge clock);
        ev = 1'b0;
        if (rst) begin
            exp_vld = 1'b0;
            exp_ovr = 1'b0;
            exp_q.delete();
        end else begin
            if (cmpl) begin
                if (!exp_vld || rdy) begin
                    exp_q.push_back({err, w});
                    exp_vld = 1'b1;
                end else begin
                    ev = 1'b1;
                end
            end else if (exp_vld && rdy) begin
                exp_vld = 1'b0;
            end
            if (OVR_EXP && ev) exp_ovr = 1'b1;
            else if (OVR_EXP && clr) exp_ovr = 1'b0;
        end
        drops += int'(ev);
        #1;
    endtask

    // en_mode: 0 all, 1 alternate, 2 random. rdy_mode: 0 low, 1 high, 2 random, 3 only on completion.
    task automatic frame(input logic [W:0] w, input int flip, input int en_mode, input int rdy_mode,
                         input int stop_at, input bit rclr);
        int fc  = 0;
        int cyc = 0;
        bit en, z, rdy, clr;
        while (fc < 16 && fc != stop_at) begin
            case (en_mode)
                0:       en = 1'b1;
                1:       en = (cyc % 2) == 1;
                default: en = $urandom_range(0, 3) != 0;
            endcase
            z = en ? (enc(w, fc) ^ (fc == flip)) : 1'($urandom_range(0, 1));
            case (rdy_mode)
                0:       rdy = 1'b0;
                1:       rdy = 1'b1;
                2:       rdy = $urandom_range(0, 1) == 1;
                default: rdy = en && fc == 15;
            endcase
            clr = rclr && ($urandom_range(0, 7) == 0);
            step(1'b0, en, z, rdy, clr, en && fc == 15, w, flip >= 0);
            if (en) fc++;
            cyc++;
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), rdy, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [W:0] w;
        int         flip;
        reset = 1'b1; pp_0 = 1'b0; pz = 1'b0; pready = 1'b0; povr_clr = 1'b0;
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        mon_en = 1'b1;
        check("rst_pc", int'(pc), 0);
        check("rst_perr", int'(perr), 0);
        check("rst_pvalid", int'(pvalid), 0);

        // Clean frame, then the same stream with gaps in the enable
        frame(5'b10110, -1, 0, 1, -1, 1'b0);
        idle(2, 1'b1);
        frame(5'b10110, -1, 1, 1, -1, 1'b0);
        idle(2, 1'b1);

        // k=0 repeat corrupted at c=2, then a clean frame
        frame(5'b00001, 2, 0, 1, -1, 1'b0);
        frame(5'b00001, -1, 0, 1, -1, 1'b0);
        idle(2, 1'b1);

        // Two frames with no consumer: second is dropped
        frame(5'h0A, -1, 0, 0, -1, 1'b0);
        frame(5'h15, -1, 0, 0, -1, 1'b0);
        idle(2, 1'b0);
        check("ovr_after_drop", int'(povr), int'(OVR_EXP));
        check("pc_held", int'(pc), 5'h0A);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        check("ovr_cleared", int'(povr), 0);
        idle(2, 1'b1);

        // Ready only on the completion cycle of the next frame
        frame(5'h07, -1, 0, 0, -1, 1'b0);
        frame(5'h19, -1, 0, 3, -1, 1'b0);
        check("swap_pc", int'(pc), 5'h19);
        check("swap_ovr", int'(povr), 0);
        idle(2, 1'b1);

        // Reset at c=9 with a word pending
        frame(5'h0C, -1, 0, 0, -1, 1'b0);
        frame(5'h13, -1, 0, 0, 9, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        check("midrst_pc", int'(pc), 0);
        check("midrst_perr", int'(perr), 0);
        check("midrst_pvalid", int'(pvalid), 0);
        check("midrst_povr", int'(povr), 0);
        frame(5'h13, -1, 0, 1, -1, 1'b0);
        idle(2, 1'b1);

        for (int f = 0; f < 40; f++) begin
            w    = W'(0) + 5'($urandom_range(0, 31));
            flip = $urandom_range(0, 7) < 3 ? $urandom_range(0, 15) : -1;
            if (flip >= 0 && first_occ(flip)) flip = -1;
            frame(w, flip, 2, 2, -1, 1'b1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4), 1'($urandom_range(0, 1)));
        end

        idle(6, 1'b1);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
